// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: opcode encodings, FSM state
// encoding and register-file geometry.
package alu_pkg;

  localparam int NUM_REGS = 4;
  localparam int IDX_W    = 2;
  localparam int DATA_W   = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Only add and subtract produce a meaningful overflow flag.
  function automatic logic op_has_flag(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small operand register file: two combinational read ports, one
// synchronous write port, cleared by synchronous reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int REGS = NUM_REGS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_a_idx_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  input  logic [IDX_W-1:0]  rd_b_idx_i,
  output logic [DATA_W-1:0] rd_b_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] regs_q [REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else if (wr_en_i) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_a_data_o = regs_q[rd_a_idx_i];
  assign rd_b_data_o = regs_q[rd_b_idx_i];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer that feeds an external combinational ALU from a
// 4x8 register file and writes the result back, one instruction per 4 cycles.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int REGS = NUM_REGS
) (
  input  logic              clock,
  input  logic              reset,
  // Handshake: an instruction transfers on a rising edge where
  // instr_valid && instr_ready; instr_ready is high only in IDLE out of reset.
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [IDX_W-1:0]  instr_rd,
  input  logic [IDX_W-1:0]  instr_ra,
  input  logic [IDX_W-1:0]  instr_rb,
  input  logic              instr_cin,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_overflow,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_overflow,
  output logic [IDX_W-1:0]  res_rd,
  output logic [1:0]        dbg_state
);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  rd_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [2:0]        alu_sel_q;
  logic              alu_cin_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_ovf_q;
  logic [IDX_W-1:0]  res_rd_q;

  logic              accept;
  logic              load_live;
  logic [DATA_W-1:0] rf_a, rf_b, opnd_a, opnd_b;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign instr_ready = (state_q == ST_IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign load_live   = load_en && (state_q == ST_IDLE);

  alu_regfile #(.REGS(REGS)) u_rf (
    .clock       (clock),
    .reset       (reset),
    .rd_a_idx_i  (instr_ra),
    .rd_a_data_o (rf_a),
    .rd_b_idx_i  (instr_rb),
    .rd_b_data_o (rf_b),
    .wr_en_i     (wr_en),
    .wr_idx_i    (wr_idx),
    .wr_data_i   (wr_data)
  );

  // A load landing on the same edge as the accept must be visible to the
  // operands, so forward it around the register file.
  assign opnd_a = (load_live && (load_idx == instr_ra)) ? load_data : rf_a;
  assign opnd_b = (load_live && (load_idx == instr_rb)) ? load_data : rf_b;

  // Writeback owns the write port in CAPTURE; loads are only honoured in IDLE.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = load_idx;
    wr_data = load_data;
    if (state_q == ST_CAPTURE) begin
      wr_en   = 1'b1;
      wr_idx  = rd_q;
      wr_data = alu_out;
    end else if (load_live) begin
      wr_en   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      alu_cin_q  <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      res_rd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q      <= instr_rd;
        alu_a_q   <= opnd_a;
        alu_b_q   <= opnd_b;
        alu_sel_q <= instr_op;
        alu_cin_q <= instr_cin & (instr_op == ALU_ADD);
      end
      if (state_q == ST_CAPTURE) begin
        res_data_q <= alu_out;
        // Masking keeps an undefined flag from a logic op out of the result.
        res_ovf_q  <= alu_overflow & op_has_flag(alu_sel_q);
        res_rd_q   <= rd_q;
      end
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign alu_cin      = alu_cin_q;
  assign res_valid    = (state_q == ST_DONE);
  assign res_data     = res_data_q;
  assign res_overflow = res_ovf_q;
  assign res_rd       = res_rd_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to the
// alu_* ports; expected values are hand-computed constants.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [1:0] instr_rd = '0, instr_ra = '0, instr_rb = '0;
  logic       instr_cin = 1'b0;
  logic       load_en = 1'b0;
  logic [1:0] load_idx = '0;
  logic [7:0] load_data = '0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       alu_cin, alu_overflow;
  logic       res_valid, res_overflow;
  logic [7:0] res_data;
  logic [1:0] res_rd, dbg_state;

  int n_vec = 0;
  int n_miscmp = 0;

  alu_sequencer dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
    .instr_rb(instr_rb), .instr_cin(instr_cin),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_data(res_data),
    .res_overflow(res_overflow), .res_rd(res_rd), .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 clock = ~clock;

  // ---- behavioural ALU; alu_junk stands in for a garbage flag on logic ops ----
  logic       alu_junk = 1'b0;
  logic [8:0] sum9;
  always_comb begin
    sum9         = '0;
    alu_out      = '0;
    alu_overflow = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        sum9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_out = sum9[7:0];
        alu_overflow = sum9[8];
      end
      ALU_SUB: begin
        sum9 = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = sum9[7:0];
        alu_overflow = sum9[8];
      end
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_NOT: alu_out = ~alu_a;
      ALU_SHL: alu_out = alu_a << 1;
      default: alu_out = alu_a >> 1;
    endcase
    if (alu_junk && !((alu_sel == ALU_ADD) || (alu_sel == ALU_SUB))) alu_overflow = 1'b1;
  end

  // ---- checker ----
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---- driver tasks ----
  logic [7:0] got_data, got_a, got_b;
  logic [2:0] got_sel;
  logic       got_ovf, got_cin, got_after;
  logic [1:0] got_rd;
  int         got_lat;

  task automatic load_reg(input logic [1:0] idx, input logic [7:0] dat);
    @(negedge clock);
    load_en = 1'b1; load_idx = idx; load_data = dat;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                     input logic [1:0] rb, input logic cin, input bit ld_now,
                     input bit ld_cap, input logic [1:0] lidx, input logic [7:0] ldat);
    int waited;
    @(negedge clock);
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_cin = cin;
    instr_valid = 1'b1;
    load_en = ld_now; load_idx = lidx; load_data = ldat;
    waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
    @(negedge clock);
    instr_valid = 1'b0; load_en = 1'b0;
    got_lat = 0;
    while (!res_valid && got_lat < 10) begin
      @(negedge clock);
      got_lat++;
      if (dbg_state == ST_CAPTURE) begin
        got_a = alu_a; got_b = alu_b; got_sel = alu_sel; got_cin = alu_cin;
        if (ld_cap) begin
          load_en = 1'b1; load_idx = lidx; load_data = ldat;
        end
      end else begin
        load_en = 1'b0;
      end
    end
    load_en = 1'b0;
    got_data = res_data; got_ovf = res_overflow; got_rd = res_rd;
    @(negedge clock);
    got_after = res_valid;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
    run(ALU_OR, idx, idx, idx, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    val = got_data;
  endtask

  // ---- directed vectors for the op table (rd=2, R0=A5, R1=3C) ----
  typedef struct {
    logic [2:0] op; logic [1:0] ra; logic [1:0] rb; logic cin;
    logic [7:0] exp_a; logic [7:0] exp_b; logic exp_cin;
    logic [7:0] exp_d; logic exp_v;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [7:0] rv;
    int cyc, n_acc, acc0, acc1, nres, pulses;
    logic [7:0] res_seen [2];

    vecs[0] = '{ALU_AND, 2'd0, 2'd1, 1'b0, 8'hA5, 8'h3C, 1'b0, 8'h24, 1'b0};
    vecs[1] = '{ALU_OR,  2'd0, 2'd1, 1'b0, 8'hA5, 8'h3C, 1'b0, 8'hBD, 1'b0};
    vecs[2] = '{ALU_XOR, 2'd0, 2'd1, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'h99, 1'b0};
    vecs[3] = '{ALU_SHL, 2'd0, 2'd1, 1'b0, 8'hA5, 8'h3C, 1'b0, 8'h4A, 1'b0};
    vecs[4] = '{ALU_SHR, 2'd0, 2'd1, 1'b0, 8'hA5, 8'h3C, 1'b0, 8'h52, 1'b0};
    vecs[5] = '{ALU_SUB, 2'd1, 2'd0, 1'b0, 8'h3C, 8'hA5, 1'b0, 8'h97, 1'b1};
    vecs[6] = '{ALU_ADD, 2'd0, 2'd1, 1'b1, 8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0};

    // ---- reset ----
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {24'd0, res_data}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    reset = 1'b0;
    #1 chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);

    // ---- add with carry-out: FF + 01 ----
    load_reg(2'd0, 8'hFF);
    load_reg(2'd1, 8'h01);
    run(ALU_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("add_sel", {29'd0, got_sel}, 32'd0);
    chk("add_a", {24'd0, got_a}, 32'hFF);
    chk("add_b", {24'd0, got_b}, 32'h01);
    chk("add_data", {24'd0, got_data}, 32'h00);
    chk("add_ovf", {31'd0, got_ovf}, 32'd1);
    chk("add_rd", {30'd0, got_rd}, 32'd2);
    chk("add_latency", got_lat, 32'd2);
    chk("add_one_pulse", {31'd0, got_after}, 32'd0);
    read_reg(2'd2, rv);
    chk("add_r2", {24'd0, rv}, 32'h00);

    // ---- not with garbage overflow from the ALU ----
    alu_junk = 1'b1;
    load_reg(2'd0, 8'hFF);
    load_reg(2'd3, 8'h77);
    run(ALU_NOT, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("not_data", {24'd0, got_data}, 32'h00);
    chk("not_ovf", {31'd0, got_ovf}, 32'd0);
    read_reg(2'd3, rv);
    chk("not_r3", {24'd0, rv}, 32'h00);

    // ---- op table ----
    load_reg(2'd0, 8'hA5);
    load_reg(2'd1, 8'h3C);
    for (int i = 0; i < 7; i++) begin
      run(vecs[i].op, 2'd2, vecs[i].ra, vecs[i].rb, vecs[i].cin, 1'b0, 1'b0, 2'd0, 8'd0);
      chk($sformatf("tbl%0d_sel", i), {29'd0, got_sel}, {29'd0, vecs[i].op});
      chk($sformatf("tbl%0d_a", i), {24'd0, got_a}, {24'd0, vecs[i].exp_a});
      chk($sformatf("tbl%0d_b", i), {24'd0, got_b}, {24'd0, vecs[i].exp_b});
      chk($sformatf("tbl%0d_cin", i), {31'd0, got_cin}, {31'd0, vecs[i].exp_cin});
      chk($sformatf("tbl%0d_data", i), {24'd0, got_data}, {24'd0, vecs[i].exp_d});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, got_ovf}, {31'd0, vecs[i].exp_v});
      chk($sformatf("tbl%0d_rd", i), {30'd0, got_rd}, 32'd2);
    end
    alu_junk = 1'b0;
    repeat (3) @(negedge clock);
    chk("res_hold", {24'd0, res_data}, 32'hE2);
    read_reg(2'd2, rv);
    chk("tbl_r2", {24'd0, rv}, 32'hE2);

    // ---- held valid: back-to-back R1 += R1 ----
    load_reg(2'd1, 8'h01);
    @(negedge clock);
    instr_op = ALU_ADD; instr_rd = 2'd1; instr_ra = 2'd1; instr_rb = 2'd1; instr_cin = 1'b0;
    instr_valid = 1'b1;
    cyc = 0; n_acc = 0; acc0 = 0; acc1 = 0; nres = 0;
    res_seen[0] = '0; res_seen[1] = '0;
    while (n_acc < 2 && cyc < 30) begin
      if (instr_ready) begin
        if (n_acc == 0) acc0 = cyc; else acc1 = cyc;
        n_acc++;
      end
      @(negedge clock);
      cyc++;
      if (res_valid && nres < 2) begin res_seen[nres] = res_data; nres++; end
    end
    instr_valid = 1'b0;
    while (nres < 2 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (res_valid) begin res_seen[nres] = res_data; nres++; end
    end
    chk("b2b_accepts", n_acc, 32'd2);
    chk("b2b_spacing", acc1 - acc0, 32'd4);
    chk("b2b_res0", {24'd0, res_seen[0]}, 32'h02);
    chk("b2b_res1", {24'd0, res_seen[1]}, 32'h04);

    // ---- reset during ISSUE aborts ----
    load_reg(2'd0, 8'h10);
    load_reg(2'd1, 8'h20);
    @(negedge clock);
    instr_op = ALU_ADD; instr_rd = 2'd2; instr_ra = 2'd0; instr_rb = 2'd1; instr_cin = 1'b0;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    chk("abort_in_issue", {30'd0, dbg_state}, {30'd0, ST_ISSUE});
    reset = 1'b1;
    #1 chk("abort_ready_low", {31'd0, instr_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("abort_ready_high", {31'd0, instr_ready}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (res_valid) pulses++;
    end
    chk("abort_no_pulse", pulses, 32'd0);
    read_reg(2'd2, rv);
    chk("abort_r2", {24'd0, rv}, 32'h00);

    // ---- load ignored outside IDLE, forwarded when concurrent in IDLE ----
    load_reg(2'd0, 8'h11);
    run(ALU_OR, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h55);
    chk("cap_load_res", {24'd0, got_data}, 32'h11);
    read_reg(2'd0, rv);
    chk("cap_load_r0", {24'd0, rv}, 32'h11);
    run(ALU_AND, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h55);
    chk("idle_load_fwd", {24'd0, got_data}, 32'h55);
    read_reg(2'd1, rv);
    chk("idle_load_r1", {24'd0, rv}, 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: REGS, default 4, number of 8-bit operand registers; fixed at 4, so the index width is 2.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: instr_valid  in  1  instruction offered.
REQ-006 Port: instr_ready  out  1  block can accept an instruction.
REQ-007 Port: instr_op  in  3  ALU select: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl A, 111 shr A.
REQ-008 Ports: instr_rd / instr_ra / instr_rb  in  2 each  destination / operand-A / operand-B register index.
REQ-009 Port: instr_cin  in  1  carry-in for add.
REQ-010 Ports: load_en  in  1, load_idx  in  2, load_data  in  8  register preload.
REQ-011 Ports: alu_a / alu_b  out  8 each, alu_sel  out  3, alu_cin  out  1  drive the combinational ALU.
REQ-012 Ports: alu_out  in  8, alu_overflow  in  1  ALU result.
REQ-013 Ports: res_valid  out  1, res_data  out  8, res_overflow  out  1, res_rd  out  2  completion report.

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE, DONE.
REQ-015 instr_ready SHALL be 1 only in IDLE with reset low.
REQ-016 In IDLE, instr_valid&instr_ready SHALL latch op/rd/ra/rb/cin at the clock edge, and the FSM SHALL go to ISSUE.
REQ-017 In ISSUE, registered outputs SHALL be alu_a=R[ra], alu_b=R[rb], alu_sel=op, and alu_cin=cin (op 000 only, else 0); the next state SHALL be CAPTURE.
REQ-018 alu_a/alu_b/alu_sel/alu_cin SHALL hold their values through ISSUE and CAPTURE, giving the ALU one full cycle to settle.
REQ-019 At the CAPTURE edge, the block SHALL sample alu_out into res_data, write R[rd]=alu_out, set res_rd=rd, and go to DONE.
REQ-020 res_overflow SHALL equal alu_overflow for op 000/001 and be forced to 0 for ops 010-111; an X from the ALU SHALL never propagate.
REQ-021 In DONE, res_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-022 res_data/res_overflow/res_rd SHALL hold their values until the next CAPTURE.
REQ-023 Latency SHALL be as follows: accept edge E0 -> res_valid high in the cycle after E0+2; throughput is one instruction per 4 cycles.
REQ-024 A load (load_en=1) SHALL write R[load_idx]=load_data only in IDLE, and SHALL be ignored in all other states.
REQ-025 A load and an accepted instruction in the same IDLE cycle SHALL both take effect; the instruction SHALL read the newly loaded value.
REQ-026 ra==rb and rd==ra/rb SHALL be legal; operands SHALL be read in ISSUE, before writeback.
REQ-027 A following instruction SHALL observe the previous writeback (no hazard, since it is accepted after DONE).
REQ-028 All arithmetic SHALL be 8-bit modulo, performed by the ALU; the sequencer SHALL do no arithmetic itself.

Reset
REQ-029 Reset SHALL clear R[0..3], all latched fields, and all outputs to 0, and put the FSM in IDLE; instr_ready SHALL be 0 while reset is high and 1 on the first cycle after.
REQ-030 Reset in any state SHALL abort the operation: no writeback and no res_valid pulse.

Structure
REQ-031 Shared package alu_pkg SHALL hold the opcode constants (ALU_ADD..ALU_SHR) and the FSM state encoding.
REQ-032 A sub-module alu_regfile SHALL provide 4x8 registers, two combinational read ports, and one write port; the sequencer SHALL mux the load and writeback requests onto that write port.

Verification
REQ-033 Preload R0=0xFF, R1=0x01; issue add rd=2 ra=0 rb=1 cin=0 with the real ALU -> alu_sel=000, res_data=0x00, res_overflow=1, res_rd=2, R2=0x00, res_valid 2 edges after accept.
REQ-034 Preload R0=0xFF; issue not rd=3 ra=0; ALU stub drives alu_overflow=X -> res_data=0x00, res_overflow=0, R3=0x00.
REQ-035 Hold instr_valid=1 with add rd=1 ra=1 rb=1 (R1=0x01) followed by the same instruction -> second accept exactly 4 cycles after the first; results 0x02 then 0x04.
REQ-036 Assert reset for 1 cycle while in ISSUE of an instruction with rd=2 -> no res_valid, R2=0x00, instr_ready=1 on the cycle after reset.
REQ-037 Pulse load_en idx=0 data=0x55 during CAPTURE -> R0 unchanged; the same load in IDLE together with an and rd=1 ra=0 rb=0 -> res_data=0x55.
